sm_hex_display_mux: RTL

Parametrised, time-multiplexed hexadecimal seven-segment scanner. Drives DIGITS common-cathode or common-anode digits through one shared segment bus plus per-digit select lines. Replaces fixed three-digit board-level display logic for GPIO-attached displays. Adds:
- tear-free frame latching of the input value
- per-digit decimal points
- 16-level brightness control
- an optional leading-zero blanking feature

Instantiated in board tops next to sm_top, fed from gpioOutput or regData.

---
 rtl/sm_hex_display_mux.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sm_hex_display_mux.sv
// sm_hex_display_mux
// Time-multiplexed hexadecimal seven-segment scanner. One shared segment bus
// plus one select line per digit. The displayed value is latched once per frame,
// so a value that changes during a scan never appears half-updated on the display.
// Brightness is set by how many of the 16 phases in each digit slot are lit.
//
// Parameters:
//   DIGITS         number of digits scanned (1..8)
//   SUB_DIV        clocks per brightness phase (>=1)
//   SEG_ACTIVE_LOW 1 = seg/seg_dp driven low to light
//   DIG_ACTIVE_LOW 1 = dig_sel driven low to select
//
// Ports:
//   clkIn       in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   scan run; 0 freezes counters and darkens the display
//   value       in   nibble k shown on digit k (digit 0 = least significant)
//   dp          in   decimal point per digit
//   brightness  in   lit phases per slot (0 = dark, 15 = 15/16 duty)
//   seg         out  segments a..g on bits 0..6
//   seg_dp      out  decimal point segment
//   dig_sel     out  one-hot digit select
//   frame       out  one-cycle pulse at the start of each new frame
//
// Optional feature: define SM_HEX_MUX_BLANK_EN to blank leading zeros.

module sm_hex_display_mux #(
  parameter int DIGITS         = 4,
  parameter int SUB_DIV        = 3125,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clkIn,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame
);

  localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SUB_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [SUB_W-1:0]    sub_q;
  logic [3:0]          phase_q;
  logic [IDX_W-1:0]    idx_q;
  logic [4*DIGITS-1:0] shadowVal_q;
  logic [DIGITS-1:0]   shadowDp_q;

  logic [6:0]          seg_q, seg_d;
  logic                segDp_q, segDp_d;
  logic [DIGITS-1:0]   digSel_q, digSel_d;
  logic                frame_q, frame_d;

  logic                tick;
  logic                frameTick;
  logic                lit;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          curNib;
  logic                curDp;
  logic                curBlank;
  logic [DIGITS-1:0]   curOneHot;
  logic [6:0]          segOn;

  // Active-high hex glyphs, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hexDecode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // A tick closes a digit slot; the tick on the last digit closes the frame.
  always_comb begin
    tick      = enable & (sub_q == SUB_LAST) & (phase_q == 4'hF);
    frameTick = tick & (idx_q == IDX_LAST);
  end

  // Scan counters. All three freeze while enable is low so the scan resumes
  // exactly where it stopped.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      sub_q   <= '0;
      phase_q <= '0;
      idx_q   <= '0;
    end else if (enable) begin
      if (sub_q == SUB_LAST) begin
        sub_q   <= '0;
        phase_q <= phase_q + 4'd1;
      end else begin
        sub_q <= sub_q + SUB_W'(1);
      end
      if (tick) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Shadow copy of value/dp, loaded only at the frame boundary so a whole
  // frame always shows one consistent value.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      shadowVal_q <= '0;
      shadowDp_q  <= '0;
    end else if (frameTick) begin
      shadowVal_q <= value;
      shadowDp_q  <= dp;
    end
  end

`ifdef SM_HEX_MUX_BLANK_EN
  logic higherZero;

  // Walk down from the top digit: a digit is blank while it and every digit
  // above it hold zero. Digit 0 is never blanked.
  always_comb begin
    blank      = '0;
    higherZero = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      higherZero = higherZero & (shadowVal_q[4*k +: 4] == 4'h0);
      blank[k]   = higherZero;
    end
  end
`else
  always_comb begin
    blank = '0;
  end
`endif

  // Pick the nibble, dp and blank flag of the digit currently being scanned.
  always_comb begin
    curNib    = '0;
    curDp     = 1'b0;
    curBlank  = 1'b0;
    curOneHot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        curNib       = shadowVal_q[4*k +: 4];
        curDp        = shadowDp_q[k];
        curBlank     = blank[k];
        curOneHot[k] = 1'b1;
      end
    end
  end

  // Next output values: lit only for the first 'brightness' phases of a slot.
  always_comb begin
    lit      = enable & (phase_q < brightness);
    segOn    = curBlank ? 7'h00 : hexDecode(curNib);
    seg_d    = SEG_OFF;
    segDp_d  = DP_OFF;
    digSel_d = DIG_OFF;
    if (lit) begin
      seg_d    = (SEG_ACTIVE_LOW != 0) ? ~segOn : segOn;
      segDp_d  = (SEG_ACTIVE_LOW != 0) ? ~curDp : curDp;
      digSel_d = (DIG_ACTIVE_LOW != 0) ? ~curOneHot : curOneHot;
    end
    frame_d = frameTick;
  end

  // Registered outputs; reset drives everything to the inactive level.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= SEG_OFF;
      segDp_q  <= DP_OFF;
      digSel_q <= DIG_OFF;
      frame_q  <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      segDp_q  <= segDp_d;
      digSel_q <= digSel_d;
      frame_q  <= frame_d;
    end
  end

  assign seg     = seg_q;
  assign seg_dp  = segDp_q;
  assign dig_sel = digSel_q;
  assign frame   = frame_q;

endmodule
